// File: rtl/icetap_capture_ctrl.sv
// icetap capture controller: registers the probe bus, evaluates a
// mask/value/edge trigger and drives the record RAM as a circular buffer.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no capture; waiting for arm
// ARMED | pre-trigger recording, watching for a trigger hit
// POST  | trigger seen, recording the remaining post-trigger samples
// DONE  | capture finished; trig_addr/wrapped hold until next arm
module icetap_capture_ctrl #(
  parameter int unsigned NR_SIGNALS   = 16,
  parameter int unsigned RECORD_DEPTH = 256,
  parameter int unsigned ADDR_BITS    = 8
) (
  input  logic                  clk,
  input  logic                  reset_,
  input  logic [NR_SIGNALS-1:0] signals_in,
  input  logic                  arm,
  input  logic                  abort,
  input  logic [NR_SIGNALS-1:0] trig_mask,
  input  logic [NR_SIGNALS-1:0] trig_value,
  input  logic [NR_SIGNALS-1:0] trig_edge_mask,
  input  logic [ADDR_BITS-1:0]  post_trig_cnt,
  output logic                  mem_wr_ena,
  output logic [ADDR_BITS-1:0]  mem_wr_addr,
  output logic [NR_SIGNALS-1:0] mem_wr_data,
  output logic [1:0]            state,
  output logic [ADDR_BITS-1:0]  trig_addr,
  output logic                  wrapped,
  output logic                  done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_POST  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(RECORD_DEPTH - 1);
  localparam logic [ADDR_BITS-1:0] ONE       = ADDR_BITS'(1);

  state_t                  state_q;
  logic [NR_SIGNALS-1:0]   sample_q;
  logic [NR_SIGNALS-1:0]   prev_q;
  logic [ADDR_BITS-1:0]    wr_ptr;
  logic [ADDR_BITS-1:0]    remain;
  logic                    first_q;

  logic                    val_hit;
  logic                    edge_seen;
  logic                    edge_hit;
  logic                    hit;
  logic                    do_write;
  logic                    start;

  assign state = state_q;

  // prev_q is stale on the first armed cycle, so edges are ignored there
  // unless no edge is required at all.
  assign val_hit   = (((sample_q ^ trig_value) & trig_mask) == '0);
  assign edge_seen = (((sample_q ^ prev_q) & trig_edge_mask) != '0);
  assign edge_hit  = (trig_edge_mask == '0) || (edge_seen && !first_q);
  assign hit       = val_hit && edge_hit;

  assign do_write = !abort && ((state_q == S_ARMED) || (state_q == S_POST));
  assign start    = !abort && arm && ((state_q == S_IDLE) || (state_q == S_DONE));

  // Probe bus pipeline, running in every state.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      sample_q <= '0;
      prev_q   <= '0;
    end else begin
      sample_q <= signals_in;
      prev_q   <= sample_q;
    end
  end

  // RAM write port, write pointer and wrap flag.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      mem_wr_ena  <= 1'b0;
      mem_wr_addr <= '0;
      mem_wr_data <= '0;
      wr_ptr      <= '0;
      wrapped     <= 1'b0;
    end else begin
      mem_wr_ena <= do_write;
      if (start) begin
        wr_ptr  <= '0;
        wrapped <= 1'b0;
      end else if (do_write) begin
        mem_wr_addr <= wr_ptr;
        mem_wr_data <= sample_q;
        wr_ptr      <= wr_ptr + ONE;
        if (wr_ptr == LAST_ADDR) wrapped <= 1'b1;
      end
    end
  end

  // Capture FSM; done is registered so it rises with the final write strobe.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q   <= S_IDLE;
      trig_addr <= '0;
      remain    <= '0;
      first_q   <= 1'b0;
      done      <= 1'b0;
    end else begin
      first_q <= 1'b0;
      if (abort) begin
        state_q <= S_IDLE;
        done    <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE, S_DONE: begin
            if (arm) begin
              state_q <= S_ARMED;
              first_q <= 1'b1;
              done    <= 1'b0;
            end
          end
          S_ARMED: begin
            if (hit) begin
              trig_addr <= wr_ptr;
              remain    <= post_trig_cnt;
              if (post_trig_cnt == '0) begin
                state_q <= S_DONE;
                done    <= 1'b1;
              end else begin
                state_q <= S_POST;
              end
            end
          end
          S_POST: begin
            remain <= remain - ONE;
            if (remain == ONE) begin
              state_q <= S_DONE;
              done    <= 1'b1;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_icetap_capture_ctrl.sv
// Scoreboard bench for icetap_capture_ctrl: directed scenarios push the
// hand-computed write sequence; a negedge monitor pops and compares.
module tb_icetap_capture_ctrl;

  logic        clk = 1'b0;
  logic        reset_;
  logic [15:0] signals_in;
  logic        arm, abort;
  logic [15:0] trig_mask, trig_value, trig_edge_mask;
  logic [7:0]  post_trig_cnt;
  logic        mem_wr_ena;
  logic [7:0]  mem_wr_addr;
  logic [15:0] mem_wr_data;
  logic [1:0]  state;
  logic [7:0]  trig_addr;
  logic        wrapped;
  logic        done;

  icetap_capture_ctrl #(.NR_SIGNALS(16), .RECORD_DEPTH(256), .ADDR_BITS(8)) dut (
    .clk(clk), .reset_(reset_), .signals_in(signals_in), .arm(arm), .abort(abort),
    .trig_mask(trig_mask), .trig_value(trig_value), .trig_edge_mask(trig_edge_mask),
    .post_trig_cnt(post_trig_cnt), .mem_wr_ena(mem_wr_ena), .mem_wr_addr(mem_wr_addr),
    .mem_wr_data(mem_wr_data), .state(state), .trig_addr(trig_addr),
    .wrapped(wrapped), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  addr;
    logic [15:0] data;
    logic        last;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   wrap_seen = 0;
  logic [7:0] last_addr = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_state"},   state, 2'd0);
    check({tag, "_wr_ena"},  mem_wr_ena, 1'b0);
    check({tag, "_wr_addr"}, mem_wr_addr, 8'h00);
    check({tag, "_wr_data"}, mem_wr_data, 16'h0000);
    check({tag, "_trig"},    trig_addr, 8'h00);
    check({tag, "_wrapped"}, wrapped, 1'b0);
    check({tag, "_done"},    done, 1'b0);
  endtask

  task automatic push(input int addr, input int data, input bit last);
    exp_t e;
    e.addr = 8'(addr);
    e.data = 16'(data);
    e.last = last;
    q.push_back(e);
  endtask

  task automatic config_trig(input logic [15:0] m, input logic [15:0] v,
                             input logic [15:0] em, input logic [7:0] p);
    trig_mask = m; trig_value = v; trig_edge_mask = em; post_trig_cnt = p;
  endtask

  // Monitor: every write strobe must match the head of the expected queue.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (mem_wr_ena === 1'b1) begin
      if (q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_write: addr %0h data %0h, expected no write (t=%0t)",
                 mem_wr_addr, mem_wr_data, $time);
      end else begin
        e = q.pop_front();
        check("wr_addr", mem_wr_addr, e.addr);
        check("wr_data", mem_wr_data, e.data);
        check("done_with_write", done, e.last);
      end
      if (last_addr == 8'hFF && mem_wr_addr == 8'h00) wrap_seen++;
      last_addr = mem_wr_addr;
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int w0;
    reset_ = 1'b0; arm = 1'b0; abort = 1'b0; signals_in = '0;
    config_trig(16'h0, 16'h0, 16'h0, 8'd0);
    #1;
    check_reset("por");
    cyc(); cyc();
    reset_ = 1'b1;
    cyc();

    // Value trigger on low byte 0x42 of a running count; trigger at k=18.
    config_trig(16'h00FF, 16'h0042, 16'h0000, 8'd4);
    for (int k = 0; k <= 22; k++) push(k, 16'h1230 + k, k == 22);
    for (int i = 0; i < 30; i++) begin
      signals_in = 16'h1230 + 16'(i);
      arm = (i == 0);
      cyc();
    end
    arm = 1'b0;
    check("val_queue_empty", q.size(), 0);
    check("val_trig_addr", trig_addr, 8'd18);
    check("val_state", state, 2'd3);
    check("val_done", done, 1'b1);
    check("val_wrapped", wrapped, 1'b0);

    // arm and abort together from DONE: abort wins, trig_addr held.
    arm = 1'b1; abort = 1'b1;
    cyc();
    arm = 1'b0; abort = 1'b0;
    check("armabort_state", state, 2'd0);
    check("armabort_done", done, 1'b0);
    check("armabort_trig", trig_addr, 8'd18);
    for (int i = 0; i < 4; i++) cyc();

    // Edge trigger on bit0 rising after 10 low samples.
    config_trig(16'h0000, 16'h0000, 16'h0001, 8'd2);
    for (int k = 0; k <= 12; k++) push(k, (k << 4) | (k >= 10 ? 1 : 0), k == 12);
    for (int i = 0; i < 16; i++) begin
      signals_in = 16'((i << 4) | (i >= 10 ? 1 : 0));
      arm = (i == 0);
      cyc();
    end
    arm = 1'b0;
    check("edge_queue_empty", q.size(), 0);
    check("edge_trig_addr", trig_addr, 8'd10);
    check("edge_state", state, 2'd3);

    // Wrap: 300 non-triggering samples, then bit15 set; trigger at 300 mod 256.
    config_trig(16'h8000, 16'h8000, 16'h0000, 8'd8);
    w0 = wrap_seen;
    for (int k = 0; k <= 308; k++) push(k % 256, k | (k >= 300 ? 16'h8000 : 0), k == 308);
    for (int i = 0; i < 315; i++) begin
      signals_in = 16'(i | (i >= 300 ? 16'h8000 : 0));
      arm = (i == 0);
      cyc();
    end
    arm = 1'b0;
    check("wrap_queue_empty", q.size(), 0);
    check("wrap_trig_addr", trig_addr, 8'd44);
    check("wrap_wrapped", wrapped, 1'b1);
    check("wrap_state", state, 2'd3);
    check("wrap_255_to_0", wrap_seen - w0, 1);

    // Abort in ARMED: two writes made, then IDLE next cycle with no write.
    config_trig(16'hFFFF, 16'hDEAD, 16'h0000, 8'd4);
    push(0, 16'h0100, 1'b0);
    push(1, 16'h0101, 1'b0);
    for (int i = 0; i < 4; i++) begin
      signals_in = 16'h0100 + 16'(i);
      arm = (i == 0);
      abort = (i == 3);
      cyc();
    end
    arm = 1'b0; abort = 1'b0;
    check("abort_state", state, 2'd0);
    check("abort_wr_ena", mem_wr_ena, 1'b0);
    check("abort_trig", trig_addr, 8'd44);
    for (int i = 0; i < 6; i++) cyc();
    check("abort_queue_empty", q.size(), 0);

    // Immediate trigger with post count 0: single write at 0, done with it.
    config_trig(16'h0000, 16'h0000, 16'h0000, 8'd0);
    push(0, 16'hBEEF, 1'b1);
    for (int i = 0; i < 6; i++) begin
      signals_in = 16'hBEEF;
      arm = (i == 0);
      cyc();
    end
    arm = 1'b0;
    check("imm_queue_empty", q.size(), 0);
    check("imm_trig_addr", trig_addr, 8'd0);
    check("imm_state", state, 2'd3);
    check("imm_done", done, 1'b1);

    // Reset mid-POST: four writes seen, then reset clears everything.
    config_trig(16'h0000, 16'h0000, 16'h0000, 8'd20);
    for (int k = 0; k < 4; k++) push(k, 16'h5000 + k, 1'b0);
    for (int i = 0; i < 6; i++) begin
      signals_in = 16'h5000 + 16'(i);
      arm = (i == 0);
      cyc();
    end
    arm = 1'b0;
    check("pre_reset_state", state, 2'd2);
    reset_ = 1'b0;
    #1;
    check_reset("midpost");
    @(posedge clk);
    #1;
    reset_ = 1'b1;
    for (int i = 0; i < 10; i++) cyc();
    check("postrst_queue_empty", q.size(), 0);
    check("postrst_state", state, 2'd0);
    check("postrst_wr_ena", mem_wr_ena, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/icetap_capture_ctrl.md
# icetap_capture_ctrl

Capture controller for the icetap logic analyzer. It sits between the probed `signals_in` bus and the record RAM inside `jtag_icetap`. It registers the probe bus, evaluates a mask/value/edge trigger, and drives the RAM write port as a circular buffer. After the trigger it records a programmable number of post-trigger samples, then stops and reports where the trigger sample landed so the JTAG side can unroll the buffer.

## Interface
- `NR_SIGNALS`, 16: width of probe bus and of each RAM word.
- `RECORD_DEPTH`, 256: RAM depth in words; power of two.
- `ADDR_BITS`, 8: equals log2(`RECORD_DEPTH`).

Ports:
- `clk`  in  1  sample/system clock.
- `reset_`  in  1  asynchronous, active-low reset.
- `signals_in`  in  NR_SIGNALS  probed signals, synchronous to `clk`.
- `arm`  in  1  single-cycle pulse; start a capture.
- `abort`  in  1  single-cycle pulse; return to IDLE.
- `trig_mask`  in  NR_SIGNALS  1 = bit takes part in the value compare.
- `trig_value`  in  NR_SIGNALS  required value on masked bits.
- `trig_edge_mask`  in  NR_SIGNALS  bits on which a change is required.
- `post_trig_cnt`  in  ADDR_BITS  number of samples stored after the trigger sample.
- `mem_wr_ena`  out  1  RAM write strobe.
- `mem_wr_addr`  out  ADDR_BITS  RAM write address.
- `mem_wr_data`  out  NR_SIGNALS  RAM write data.
- `state`  out  2  IDLE=0, ARMED=1, POST=2, DONE=3.
- `trig_addr`  out  ADDR_BITS  RAM address holding the trigger sample.
- `wrapped`  out  1  write pointer has wrapped at least once since `arm`.
- `done`  out  1  high while `state`==DONE.

All config inputs are quasi-static and already synchronised to `clk`. They must be held stable while the state is not IDLE or DONE.

## Operation
- Every cycle, `sample_q` <= `signals_in` and `prev_q` <= `sample_q`, in all states.
- `val_hit` = ((`sample_q` ^ `trig_value`) & `trig_mask`) == 0.
- `edge_hit` = (`trig_edge_mask` == 0) or ((`sample_q` ^ `prev_q`) & `trig_edge_mask`) != 0.
  - In the first ARMED cycle after `arm`, `edge_hit` is forced 0 unless `trig_edge_mask` == 0, because `prev_q` may be stale.
- `hit` = `val_hit` & `edge_hit`.
- IDLE: no writes. On `arm`: `wr_ptr` <= 0, `wrapped` <= 0, go to ARMED.
- ARMED: write `sample_q` at `wr_ptr`, then `wr_ptr` <= `wr_ptr`+1 modulo `RECORD_DEPTH`.
  - `wrapped` <= 1 when `wr_ptr` goes from `RECORD_DEPTH`-1 to 0.
  - On `hit`: `trig_addr` <= `wr_ptr`, `remain` <= `post_trig_cnt`.
  - Next state is DONE if `post_trig_cnt`==0, otherwise POST.
- POST: write `sample_q` and advance `wr_ptr` as in ARMED; `remain` <= `remain`-1. When `remain`==1, this cycle's write is the last one and the next state is DONE.
- DONE: no writes. `trig_addr` and `wrapped` hold. On `arm`, restart exactly as from IDLE.
- `abort` in any state: go to IDLE, no write that cycle. `abort` wins over `arm` in the same cycle.
- `arm` while in ARMED or POST is ignored.
- Total samples written after the trigger sample equals `post_trig_cnt`. Values up to `RECORD_DEPTH`-1 are legal; the oldest data is overwritten.

## Timing
- Async reset: `state`=IDLE; `mem_wr_ena`=0, `mem_wr_addr`=0, `mem_wr_data`=0; `trig_addr`=0; `wrapped`=0; `done`=0. `sample_q`, `prev_q`, `wr_ptr` and `remain` are also 0. Reset mid-capture aborts the capture with no further writes.
- `mem_wr_*`, `state` and `done` are registered.
  - A write decided in cycle C appears on `mem_wr_*` in cycle C+1.
  - A `signals_in` value present in cycle N reaches `mem_wr_data` in cycle N+2.
- Trigger latency: `signals_in` matching in cycle N → `trig_addr` valid and `state` leaves ARMED in cycle N+2.
- `done` rises in the same cycle as the final `mem_wr_ena` pulse.
- `arm` in cycle C → `state`=ARMED in C+1 → first `mem_wr_ena` in C+2, at address 0.

## Test plan
- Reset mid-POST: assert `reset_`=0 for one cycle → every output reads its reset value immediately; no `mem_wr_ena` pulses until the next `arm`.
- Value trigger: `signals_in` = free-running 16-bit count; `trig_mask`=0x00FF, `trig_value`=0x0042, `post_trig_cnt`=4, `arm` once → the RAM word at `trig_addr` has low byte 0x42; exactly 4 further writes follow; `done`=1 and `state`=3 afterwards.
- Edge trigger: `trig_mask`=0, `trig_edge_mask`=0x0001; drive bit0 low for 10 cycles, then high → trigger sample has bit0=1 and `trig_addr`=10.
- Wrap: no trigger for 300 samples, then trigger with `post_trig_cnt`=8 → `wrapped`=1; `mem_wr_addr` sequence contains 255 followed by 0; `trig_addr`=300 mod 256 = 44.
- Abort: `abort` in ARMED → IDLE the next cycle with no writes. `arm` and `abort` in the same cycle from DONE → IDLE, and `trig_addr` is unchanged.
- Immediate trigger: all masks 0, `post_trig_cnt`=0, `arm` → exactly one write at address 0; `trig_addr`=0; `done`=1 in the same cycle as that write.
